// File: rtl/secret_coeff_unpacker_if.sv
// BRAM read port and coefficient stream between the unpacker (master) and its neighbours (slave).
// Stream handshake: coeff_out/coeff_last are valid while coeff_valid is high and transfer on a clock edge with coeff_valid & coeff_ready; the master holds them stable until then.
interface secret_coeff_unpacker_if #(
    parameter int ADDR_W  = 9,
    parameter int COEFF_W = 13
);
    logic [ADDR_W-1:0]  rd_address;
    logic               rd_en;
    logic [63:0]        data_in;
    logic [COEFF_W-1:0] coeff_out;
    logic               coeff_valid;
    logic               coeff_ready;
    logic               coeff_last;

    modport master (
        output rd_address, rd_en, coeff_out, coeff_valid, coeff_last,
        input  data_in, coeff_ready
    );

    modport slave (
        input  rd_address, rd_en, coeff_out, coeff_valid, coeff_last,
        output data_in, coeff_ready
    );
endinterface

// File: rtl/secret_coeff_unpacker.sv
// Reads one polynomial of packed 4-bit sign-magnitude samples from BRAM and streams 256 two's-complement coefficients.
// Optional macro SECRET_UNPACK_CHECK_EN adds the sticky range_err output.
module secret_coeff_unpacker #(
    parameter int COEFF_W        = 13,
    parameter int ADDR_W         = 9,
    parameter int WORDS_PER_POLY = 16,
    parameter int BASE_ADDR      = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] poly_sel,
    output logic       busy,
    output logic       done,
`ifdef SECRET_UNPACK_CHECK_EN
    output logic       range_err,
`endif
    output logic [1:0] fsm_state,
    secret_coeff_unpacker_if.master bus
);
    localparam int CNT_W = $clog2(WORDS_PER_POLY + 1);
    localparam logic [CNT_W-1:0] NUM_WORDS = CNT_W'(WORDS_PER_POLY);
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS_PER_POLY - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
    state_t state;

    logic [63:0]        word_buf [2];
    logic [1:0]         held;
    logic               wr_ptr, rd_ptr;
    logic [3:0]         nib_idx;
    logic               ret;
    logic [CNT_W-1:0]   wcnt, cons_w;
`ifdef SECRET_UNPACK_CHECK_EN
    logic               coeff_bad;
`endif

    logic [63:0]        head;
    logic [3:0]         nib;
    logic               avail, out_free, take, pop, issue, accept;
    logic [1:0]         held_next, sel_eff;
    logic [ADDR_W-1:0]  start_addr;
    logic [COEFF_W-1:0] mag, coeff_next;

    // When the buffer is empty the word returning from BRAM this cycle is used directly, saving a cycle of latency.
    always_comb begin
        head       = (held != 2'd0) ? word_buf[rd_ptr] : bus.data_in;
        avail      = (held != 2'd0) || ret;
        out_free   = !bus.coeff_valid || bus.coeff_ready;
        accept     = bus.coeff_valid && bus.coeff_ready;
        take       = (state == RUN) && out_free && avail;
        nib        = head[{nib_idx, 2'b00} +: 4];
        pop        = take && (nib_idx == 4'd15);
        held_next  = held + {1'b0, ret} - {1'b0, pop};
        issue      = (state == RUN) && (wcnt < NUM_WORDS) &&
                     (({1'b0, held_next} + {2'b00, bus.rd_en}) < 3'd2);
        sel_eff    = (poly_sel == 2'd3) ? 2'd2 : poly_sel;
        start_addr = ADDR_W'(BASE_ADDR) + ADDR_W'(WORDS_PER_POLY) * ADDR_W'(sel_eff);
        mag        = COEFF_W'(nib[2:0]);
        coeff_next = nib[3] ? (~mag + COEFF_W'(1)) : mag;
    end

    assign fsm_state = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            busy            <= 1'b0;
            done            <= 1'b0;
            bus.rd_address  <= '0;
            bus.rd_en       <= 1'b0;
            bus.coeff_out   <= '0;
            bus.coeff_valid <= 1'b0;
            bus.coeff_last  <= 1'b0;
            word_buf[0]     <= '0;
            word_buf[1]     <= '0;
            held            <= 2'd0;
            wr_ptr          <= 1'b0;
            rd_ptr          <= 1'b0;
            nib_idx         <= 4'd0;
            ret             <= 1'b0;
            wcnt            <= '0;
            cons_w          <= '0;
`ifdef SECRET_UNPACK_CHECK_EN
            coeff_bad       <= 1'b0;
            range_err       <= 1'b0;
`endif
        end else begin
            ret <= bus.rd_en;
            case (state)
                IDLE: begin
                    done      <= 1'b0;
                    bus.rd_en <= 1'b0;
                    if (start) begin
                        state          <= RUN;
                        busy           <= 1'b1;
                        bus.rd_address <= start_addr;
                        bus.rd_en      <= 1'b1;
                        wcnt           <= CNT_W'(1);
                        cons_w         <= '0;
                        held           <= 2'd0;
                        wr_ptr         <= 1'b0;
                        rd_ptr         <= 1'b0;
                        nib_idx        <= 4'd0;
`ifdef SECRET_UNPACK_CHECK_EN
                        range_err      <= 1'b0;
`endif
                    end
                end
                RUN: begin
                    if (ret) begin
                        word_buf[wr_ptr] <= bus.data_in;
                        wr_ptr           <= ~wr_ptr;
                    end
                    held <= held_next;
                    if (pop) begin
                        rd_ptr <= ~rd_ptr;
                        cons_w <= cons_w + CNT_W'(1);
                    end
                    bus.rd_en <= issue;
                    if (issue) begin
                        bus.rd_address <= bus.rd_address + ADDR_W'(1);
                        wcnt           <= wcnt + CNT_W'(1);
                    end
                    if (take) begin
                        bus.coeff_out   <= coeff_next;
                        bus.coeff_valid <= 1'b1;
                        bus.coeff_last  <= (cons_w == LAST_WORD) && (nib_idx == 4'd15);
                        nib_idx         <= nib_idx + 4'd1;
`ifdef SECRET_UNPACK_CHECK_EN
                        coeff_bad       <= (nib[2:0] > 3'd4) || (nib == 4'b1000);
`endif
                    end else if (accept) begin
                        bus.coeff_valid <= 1'b0;
                        bus.coeff_last  <= 1'b0;
                    end
`ifdef SECRET_UNPACK_CHECK_EN
                    if (accept && coeff_bad) range_err <= 1'b1;
`endif
                    if (accept && bus.coeff_last) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_secret_coeff_unpacker.sv
// Bench for secret_coeff_unpacker: BRAM model, ready patterns, scoreboard fed from a nibble-level reference model.
module tb_secret_coeff_unpacker;
    logic       clk;
    logic       rst;
    logic       start;
    logic [1:0] poly_sel;
    logic       busy, done;
    logic [1:0] fsm_state;
`ifdef SECRET_UNPACK_CHECK_EN
    logic       range_err;
    logic       exp_rerr;
`endif

    secret_coeff_unpacker_if #(.ADDR_W(9), .COEFF_W(13)) bus ();

    secret_coeff_unpacker dut (
        .clk(clk), .rst(rst), .start(start), .poly_sel(poly_sel),
        .busy(busy), .done(done),
`ifdef SECRET_UNPACK_CHECK_EN
        .range_err(range_err),
`endif
        .fsm_state(fsm_state), .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [63:0] mem [512];
    logic [12:0] exp_q[$];
    logic [8:0]  exp_addr[$];
    int n_checks = 0, n_fail = 0;
    int rdy_mode = 0;
    int acc_cnt, issued, max_out, done_cnt, run_len, last_run;
    bit prev_stall, prev_last, last_acc_prev;
    logic [12:0] prev_val;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    function automatic int ref_coeff(input int n);
        int m;
        m = n % 8;
        if (n >= 8) return (8192 - m) % 8192;
        return m;
    endfunction

    // BRAM: registered read, garbage on cycles without a read.
    always @(posedge clk) begin
        if (bus.rd_en) bus.data_in <= mem[bus.rd_address];
        else           bus.data_in <= {$urandom, $urandom};
    end

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       bus.coeff_ready = 1'b1;
            1:       bus.coeff_ready = ~bus.coeff_ready;
            default: bus.coeff_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Monitor: compare every read address and every accepted coefficient against the queues.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 0; last_acc_prev = 0; run_len = 0;
        end else begin
            if (bus.rd_en) begin
                issued++;
                if (exp_addr.size() == 0) check("rd_unexpected", 1, 0);
                else check("rd_address", bus.rd_address, exp_addr.pop_front());
            end
            if (issued - (acc_cnt + (bus.coeff_valid ? 1 : 0)) / 16 > max_out)
                max_out = issued - (acc_cnt + (bus.coeff_valid ? 1 : 0)) / 16;
            if (done || last_acc_prev) begin
                check("done_pulse", done, last_acc_prev);
                if (last_acc_prev) check("valid_after_last", bus.coeff_valid, 0);
            end
            if (done) done_cnt++;
            if (prev_stall) begin
                check("stall_valid", bus.coeff_valid, 1);
                check("stall_data", bus.coeff_out, prev_val);
                check("stall_last", bus.coeff_last, prev_last);
            end
            if (bus.coeff_valid) run_len++;
            else begin
                if (run_len > 0) last_run = run_len;
                run_len = 0;
            end
            last_acc_prev = 0;
            if (bus.coeff_valid && bus.coeff_ready) begin
                if (exp_q.size() == 0) check("coeff_unexpected", 1, 0);
                else begin
                    check("coeff", bus.coeff_out, exp_q.pop_front());
                    check("coeff_last", bus.coeff_last, acc_cnt == 255);
                end
                acc_cnt++;
                if (bus.coeff_last) last_acc_prev = 1;
            end
            prev_stall = bus.coeff_valid && !bus.coeff_ready;
            prev_val   = bus.coeff_out;
            prev_last  = bus.coeff_last;
        end
    end

    task automatic wait_acc(input int n);
        bit got;
        got = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (acc_cnt >= n) begin got = 1; break; end
        end
        check("acc_reached", got, 1);
    endtask

    // Called at posedge+1; leaves at posedge+1 of the IDLE cycle following DONE.
    task automatic run_stream(input int sel, input int mode, input bit poke, input bit reset_mid, input bit tail);
        int base, n;
        bit got;
        base = 16 * ((sel == 3) ? 2 : sel);
`ifdef SECRET_UNPACK_CHECK_EN
        exp_rerr = 0;
`endif
        for (int w = 0; w < 16; w++) begin
            exp_addr.push_back(9'(base + w));
            for (int k = 0; k < 16; k++) begin
                n = int'((mem[base + w] >> (4 * k)) & 64'hF);
                exp_q.push_back(13'(ref_coeff(n)));
`ifdef SECRET_UNPACK_CHECK_EN
                if ((n % 8) > 4 || n == 8) exp_rerr = 1;
`endif
            end
        end
        acc_cnt = 0; issued = 0; max_out = 0; done_cnt = 0; last_run = 0;
        rdy_mode = mode;
        start = 1'b1; poly_sel = 2'(sel);
        @(posedge clk); #1;
        start = 1'b0; poly_sel = 2'($urandom_range(0, 3));
        @(negedge clk);
        check("lat_rd_en_t1", bus.rd_en, 1);
        check("busy_t1", busy, 1);
        check("lat_valid_t1", bus.coeff_valid, 0);
`ifdef SECRET_UNPACK_CHECK_EN
        check("range_err_cleared", range_err, 0);
`endif
        @(negedge clk);
        check("lat_valid_t2", bus.coeff_valid, 0);
        @(negedge clk);
        check("lat_valid_t3", bus.coeff_valid, 1);
        if (poke) begin
            wait_acc(50);
            @(posedge clk); #1;
            start = 1'b1; poly_sel = 2'(sel ^ 1);
            @(posedge clk); #1;
            start = 1'b0;
        end
        if (reset_mid) begin
            wait_acc(100);
            @(posedge clk); #1;
            rst = 1'b1;
            exp_q.delete(); exp_addr.delete();
            @(negedge clk);
            check("rst_rd_en", bus.rd_en, 0);
            check("rst_rd_address", bus.rd_address, 0);
            check("rst_valid", bus.coeff_valid, 0);
            check("rst_coeff", bus.coeff_out, 0);
            check("rst_last", bus.coeff_last, 0);
            check("rst_busy", busy, 0);
            check("rst_done", done, 0);
            check("rst_state", fsm_state, 0);
            @(posedge clk); #1;
            rst = 1'b0;
            return;
        end
        got = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (done) begin got = 1; break; end
        end
        check("done_seen", got, 1);
        @(posedge clk); #1;
        if (tail) begin
            repeat (4) @(posedge clk);
            #1;
        end
        check("done_count", done_cnt, 1);
        check("acc_count", acc_cnt, 256);
        check("exp_q_empty", exp_q.size(), 0);
        check("exp_addr_empty", exp_addr.size(), 0);
        check("busy_after", busy, 0);
        check("outstanding_le_2", max_out <= 2, 1);
        if (mode == 0) check("contiguous_valid", last_run, 256);
`ifdef SECRET_UNPACK_CHECK_EN
        check("range_err", range_err, exp_rerr);
`endif
    endtask

    initial begin
        for (int a = 0; a < 512; a++) mem[a] = {$urandom, $urandom};
        mem[16][15:0]  = 16'hC0B3;
        mem[0][23:20]  = 4'h8;
        rst = 1'b1; start = 1'b0; poly_sel = 2'd0; bus.coeff_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_rd_en", bus.rd_en, 0);
        check("reset_rd_address", bus.rd_address, 0);
        check("reset_valid", bus.coeff_valid, 0);
        check("reset_coeff", bus.coeff_out, 0);
        check("reset_last", bus.coeff_last, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_state", fsm_state, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        run_stream(1, 0, 0, 0, 1);
        run_stream(0, 1, 0, 0, 1);
        run_stream(2, 0, 1, 0, 0);
        run_stream(3, 2, 0, 0, 1);
        run_stream(1, 0, 0, 1, 0);
        run_stream(0, 0, 0, 0, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
